// File: rtl/load_exec_unit_pkg.sv
// Package for the load execution unit.
// It provides the typed views of the shared constants:
//   ld_size_t : access size (byte / half / word / reserved).
//   state_t   : control FSM state.
package load_exec_unit_pkg;

`include "constants.vh"

    typedef enum logic [1:0] {
        SZ_B   = LD_SIZE_B,
        SZ_H   = LD_SIZE_H,
        SZ_W   = LD_SIZE_W,
        SZ_RSV = LD_SIZE_RSV
    } ld_size_t;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_WB    = ST_WB,
        S_DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/constants.vh
// Shared constants for the load execution unit.
// Holds the default address / ROB index widths, the access-size encodings,
// and the FSM state encodings. It is pulled into load_exec_unit_pkg.
// It is also included ahead of the top module so that the width macros exist
// there. The include guard keeps the localparams from being declared twice.
`ifndef LOAD_EXEC_CONSTANTS_VH
`define LOAD_EXEC_CONSTANTS_VH

`define ADDR_WIDTH 32
`define ROB_SEL    5

localparam logic [1:0] LD_SIZE_B   = 2'b00;
localparam logic [1:0] LD_SIZE_H   = 2'b01;
localparam logic [1:0] LD_SIZE_W   = 2'b10;
localparam logic [1:0] LD_SIZE_RSV = 2'b11;  // reserved, behaves as a word

localparam logic [2:0] ST_IDLE  = 3'd0;
localparam logic [2:0] ST_REQ   = 3'd1;
localparam logic [2:0] ST_WAIT  = 3'd2;
localparam logic [2:0] ST_WB    = 3'd3;
localparam logic [2:0] ST_DRAIN = 3'd4;

`endif

// File: rtl/load_exec_unit_align_ext.sv
// load_align_ext: purely combinational extraction, extension and misalignment
// detection for a load result.
// Ports:
//   offset     : byte offset within the word (addr[1:0])
//   size       : access size
//   sign_ext   : 1 = sign-extend, 0 = zero-extend
//   raw_data   : full aligned word returned by memory
//   result     : extracted and extended load value
//   misaligned : half at an odd address, or word/reserved at a non-zero offset
// When the access is misaligned, bytes beyond the word boundary shift in as
// zero before the value is extended.
module load_align_ext
    import load_exec_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        offset,
    input  ld_size_t          size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] raw_data,
    output logic [DATA_W-1:0] result,
    output logic              misaligned
);

    logic [DATA_W-1:0] shifted;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        shifted    = raw_data >> {offset, 3'b000};
        result     = shifted;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                result = {{(DATA_W-8){sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                result     = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};
                misaligned = offset[0];
            end
            SZ_W, SZ_RSV: begin
                result     = shifted;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/load_exec_unit.sv
// load_exec_unit: single-entry load execution stage.
// The unit accepts one load from the load queue. It reads the aligned word
// from data memory, then extracts and extends the addressed byte, half or
// word. The result is offered to writeback under a valid/ready handshake.
// A flush kills the in-flight load. If a memory response is still owed at
// that point, the DRAIN state absorbs it.
// Ports:
//   clk, reset (async, active-high), flush
//   issue_*   : load queue handshake and load attributes
//   mem_req_* : word-aligned read request to memory
//   mem_resp_*: read response from memory
//   wb_*      : result toward the writeback / CDB arbiter
//   busy      : unit holds a load (state is not IDLE)
// Configuration macro: LOAD_MISALIGN_TRAP_EN.
//   Defined   : a misaligned load bypasses memory and returns wb_exc=1 with
//               wb_data=0.
//   Undefined : wb_exc is constant 0. Misaligned loads read memory as usual.
`include "constants.vh"

module load_exec_unit
    import load_exec_unit_pkg::*;
#(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int ROB_W  = `ROB_SEL,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    input  logic [1:0]        issue_size,
    input  logic              issue_signed,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ROB_W-1:0]  wb_rob_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exc,
    output logic              busy
);

    state_t   state_q, state_d;
    logic [1:0] off_q;
    ld_size_t size_q;
    logic     signed_q;

    logic              accept;
    logic              trap;
    logic [1:0]        ext_off;
    ld_size_t          ext_size;
    logic [DATA_W-1:0] ext_result;
    logic              misaligned;

    assign accept = (state_q == S_IDLE) && !flush && issue_valid;
    assign busy   = (state_q != S_IDLE);

    // In IDLE the aligner looks at the incoming load, so that misalignment is
    // known at accept time. In every other state it sees the latched load, so
    // that it can extract data from the response.
    assign ext_off  = (state_q == S_IDLE) ? issue_addr[1:0]        : off_q;
    assign ext_size = (state_q == S_IDLE) ? ld_size_t'(issue_size) : size_q;

    load_align_ext #(
        .DATA_W (DATA_W)
    ) u_align (
        .offset     (ext_off),
        .size       (ext_size),
        .sign_ext   (signed_q),
        .raw_data   (mem_resp_data),
        .result     (ext_result),
        .misaligned (misaligned)
    );

`ifdef LOAD_MISALIGN_TRAP_EN
    assign trap = misaligned;
`else
    assign trap = 1'b0;
    wire unused_misaligned = misaligned;
`endif

    // NOTE: state and data registers use non-blocking assignments, so that
    // every flop samples values from before the clock edge regardless of the
    // order in which the processes evaluate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        issue_ready   = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        case (state_q)
            S_IDLE: begin
                issue_ready = !flush;
                if (accept) begin
                    state_d = trap ? S_WB : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (flush) begin
                    // A request accepted on the flush cycle still owes a response.
                    state_d = mem_req_ready ? S_DRAIN : S_IDLE;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latched load attributes and registered data outputs. Each output is
    // loaded once per load and then holds through any backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q        <= 2'b00;
            size_q       <= SZ_B;
            signed_q     <= 1'b0;
            mem_req_addr <= '0;
            wb_rob_idx   <= '0;
            wb_data      <= '0;
            wb_exc       <= 1'b0;
        end else begin
            if (accept) begin
                off_q        <= issue_addr[1:0];
                size_q       <= ld_size_t'(issue_size);
                signed_q     <= issue_signed;
                mem_req_addr <= {issue_addr[ADDR_W-1:2], 2'b00};
                wb_rob_idx   <= issue_rob_idx;
                wb_exc       <= trap;
                if (trap) begin
                    wb_data <= '0;
                end
            end
            if ((state_q == S_WAIT) && mem_resp_valid && !flush) begin
                wb_data <= ext_result;
            end
        end
    end

endmodule

// File: doc/load_exec_unit.md
# load_exec_unit

Single-entry load execution stage that sits directly downstream of the load queue. It accepts one issued load (address, ROB index, size, sign), performs a word-aligned request/response transaction with the data memory, and extracts and extends the addressed byte, half or word. It then presents the result to the writeback/CDB arbiter under a valid/ready handshake. A flush aborts the in-flight load and discards any memory response still owed.

## Interface
- ADDR_W, default `ADDR_WIDTH: load address width.
- ROB_W, default `ROB_SEL: ROB index width.
- DATA_W, default 32: memory and result data width; fixed at 32 for this revision.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- flush  input  1  pipeline flush; kills the in-flight load.
- issue_valid  input  1  load queue presents a ready load.
- issue_ready  output  1  unit can accept a load this cycle.
- issue_addr  input  ADDR_W  byte address.
- issue_rob_idx  input  ROB_W  ROB index of the load.
- issue_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- issue_signed  input  1  1 selects sign-extend, 0 selects zero-extend.
- mem_req_valid  output  1  memory read request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  ADDR_W  word-aligned address, with bits [1:0] forced to 0.
- mem_resp_valid  input  1  read data valid.
- mem_resp_data  input  DATA_W  full aligned word.
- wb_valid  output  1  result valid.
- wb_ready  input  1  writeback arbiter accepts the result.
- wb_rob_idx  output  ROB_W  ROB index of the result.
- wb_data  output  DATA_W  extended load result.
- wb_exc  output  1  misaligned-load exception flag (see Configuration).
- busy  output  1  state is not IDLE.

## Operation
- FSM states:
  - IDLE: issue_ready = !flush. On issue_valid && issue_ready, latch addr, rob_idx, size and signed, then go to REQ (or to WB when trapping, see Configuration).
  - REQ: mem_req_valid = 1 with mem_req_addr held stable. On mem_req_ready go to WAIT.
  - WAIT: on mem_resp_valid, capture the extracted data and go to WB.
  - WB: wb_valid = 1 with wb_* held stable. On wb_ready go to IDLE.
  - DRAIN: wait for the orphaned mem_resp_valid, discard the data, go to IDLE.
- Extraction:
  - off = addr[1:0]; shifted = mem_resp_data >> (8*off).
  - Byte takes shifted[7:0]; half takes shifted[15:0]; word takes the full word.
  - Extension is sign or zero per the latched signed bit.
- Misaligned condition: half with addr[0]=1, or word/reserved with addr[1:0]!=0.
- Flush, by state:
  - IDLE: no accept.
  - REQ: if mem_req_ready is sampled the same cycle, go to DRAIN; otherwise go to IDLE.
  - WAIT: go to DRAIN, or to IDLE if mem_resp_valid arrives the same cycle.
  - WB: go to IDLE and drop the result.
  - DRAIN: stay in DRAIN.
- mem_resp_valid outside WAIT/DRAIN is ignored. Memory never responds in the same cycle as the request handshake.
- Reset mid-operation returns the unit to IDLE immediately. A response arriving after reset is ignored.

## Timing
- Reset values:
  - State IDLE.
  - mem_req_valid, wb_valid, wb_exc and busy are 0.
  - mem_req_addr, wb_rob_idx and wb_data are 0.
  - issue_ready is 1 once reset deasserts.
- mem_req_valid, wb_valid, issue_ready and busy decode combinationally from the state register. All data outputs are registered.
- Best-case latency:
  - Issue handshake at cycle N.
  - mem_req_valid at N+1.
  - Response at N+2.
  - wb_valid at N+3.
  - Next issue accepted at N+4.
- Throughput is one load per at least 4 cycles; there is no overlap.
- Backpressure on mem_req_ready or wb_ready holds the state and all outputs indefinitely.

## Configuration
- LOAD_MISALIGN_TRAP_EN:
  - Defined: a misaligned load skips memory and goes IDLE→WB directly, with wb_exc=1 and wb_data=0.
  - Undefined: wb_exc is tied to 0. Misaligned loads access memory normally with the shift from addr[1:0]; bytes beyond the word boundary read as 0 before extension.

## Structure
- The shared constants include goes in constants.vh: ADDR_WIDTH, ROB_SEL, the size encodings LD_SIZE_B/H/W, and the FSM state localparams.
- One sub-module, load_align_ext: combinational extract, extend and misalign detection.

## Test plan
- Aligned lw: addr 0x100, resp 0xDEADBEEF, wb_ready=1 → wb_data 0xDEADBEEF at cycle N+3, rob_idx preserved.
- lb signed: addr 0x103, resp 0x80112233 → 0xFFFFFF80. lbu from the same address → 0x00000080.
- Backpressure: mem_req_ready low for 3 cycles, then wb_ready low for 2 cycles → outputs held stable, exactly one writeback, issue_ready stays low throughout.
- Flush in WAIT, response 2 cycles later → no wb_valid; DRAIN consumes the response; next load issues cleanly with correct data.
- lh at 0x101 with macro defined → wb_exc=1, wb_data 0, no mem_req_valid. With macro undefined → memory access occurs and wb_exc=0.
- Reset asserted in REQ → mem_req_valid drops asynchronously, state IDLE, a stale response is ignored.
